// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg
//   Shared constants and types for the APB countdown timer completer.
//   - Word offsets (Paddr[7:2]) of the four mapped registers.
//   - Bit positions inside CTRL and STATUS.
//   - State type of the APB protocol tracker.
package apb_timer_pkg;

    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_LOAD   = 6'h01;
    localparam logic [5:0] REG_COUNT  = 6'h02;
    localparam logic [5:0] REG_STATUS = 6'h03;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;

    localparam int STAT_EXPIRED = 0;
    localparam int STAT_PROTERR = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timer_core.sv
// apb_timer_core
//   Prescaler plus countdown counter with optional auto-reload.
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   en           : timer enabled (CTRL.EN)
//   autoreload   : reload from load_val at expiry (CTRL.AUTORELOAD)
//   load_val     : reload value (LOAD register)
//   load_strobe  : one-cycle pulse, COUNT <= load_val and prescaler cleared
//   count        : current COUNT value
//   expire       : combinational pulse, a tick found COUNT == 0 this cycle
module apb_timer_core #(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             autoreload,
    input  logic [CNT_W-1:0] load_val,
    input  logic             load_strobe,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic        tick;

    // The tick coincides with the prescaler wrap, so PRESCALE = 1 ticks every cycle.
    assign tick   = en && (presc == PRESC_LAST);
    assign expire = tick && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
        end else if (load_strobe) begin
            presc <= '0;
            count <= load_val;
        end else if (en) begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
                // COUNT never underflows: zero either reloads or holds.
                if (count != '0) begin
                    count <= count - CNT_W'(1);
                end else if (autoreload) begin
                    count <= load_val;
                end
            end
        end
    end

endmodule

// File: rtl/apb_timer_completer.sv
// apb_timer_completer
//   APB completer hosting a memory-mapped countdown timer with a level IRQ.
// Ports
//   Hclk, Hreset      : clock, synchronous active-high reset
//   Psel, Penable     : APB select and enable phase
//   Pwrite            : 1 = write, 0 = read
//   Paddr, Pwdata     : byte address (Paddr[7:2] decoded), write data
//   Prdata            : read data, non-zero only during a legal read enable cycle
//   Irq               : registered EXPIRED & IRQ_EN
//   fsm_state         : APB protocol tracker state, for observation
//
// Handshake: a transfer is one setup cycle (Psel=1, Penable=0) followed by
// exactly one enable cycle (Psel=1, Penable=1) with the same Paddr[7:2] and
// Pwrite; there are no wait states. Writes commit at the edge ending the
// enable cycle, read data is captured at the edge ending setup. Any other
// sequence is a protocol error: PROTERR sets and nothing is committed.
module apb_timer_completer
    import apb_timer_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int CNT_W    = 32
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Irq,
    output apb_state_e  fsm_state
);

    apb_state_e       state, state_next;
    logic [5:0]       addr_q;
    logic             write_q;
    logic [31:0]      rdata_q, rd_mux;
    logic             latch, enable_ok, proto_err, match;
    logic             en_r, autoreload_r, irq_en_r, expired_r, proterr_r, irq_r;
    logic             en_next, en_rise;
    logic [CNT_W-1:0] load_r, count;
    logic             expire;
    logic             wr_commit, w_ctrl, w_load, w_status;
    logic             unused_bits;

    // Only the word offset is decoded; the remaining address and data bits are ignored.
    assign unused_bits = ^{Paddr[31:8], Paddr[1:0], Pwdata};

    // Enable cycle must repeat the address and direction seen in setup.
    assign match = (Paddr[7:2] == addr_q) && (Pwrite == write_q);

    always_ff @(posedge Hclk) begin
        if (Hreset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = ST_IDLE;
        latch      = 1'b0;
        enable_ok  = 1'b0;
        proto_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Penable) begin
                    proto_err = 1'b1;
                end else if (Psel) begin
                    state_next = ST_SETUP;
                    latch      = 1'b1;
                end
            end
            ST_SETUP: begin
                if (Psel && Penable) begin
                    state_next = ST_ACCESS;
                    if (match) enable_ok = 1'b1;
                    else       proto_err = 1'b1;
                end else begin
                    proto_err = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (Psel && !Penable) begin
                    state_next = ST_SETUP;
                    latch      = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_commit = enable_ok && write_q;
    assign w_ctrl    = wr_commit && (addr_q == REG_CTRL);
    assign w_load    = wr_commit && (addr_q == REG_LOAD);
    assign w_status  = wr_commit && (addr_q == REG_STATUS);
    assign en_rise   = w_ctrl && Pwdata[CTRL_EN] && !en_r;

    // A one-shot expiry clears EN even if the same edge commits a CTRL write.
    always_comb begin
        en_next = en_r;
        if (w_ctrl) en_next = Pwdata[CTRL_EN];
        if (expire && !autoreload_r) en_next = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        case (Paddr[7:2])
            REG_CTRL:   rd_mux = {29'd0, irq_en_r, autoreload_r, en_r};
            REG_LOAD:   rd_mux = 32'(load_r);
            REG_COUNT:  rd_mux = 32'(count);
            REG_STATUS: rd_mux = {30'd0, proterr_r, expired_r};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            addr_q       <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            en_r         <= 1'b0;
            autoreload_r <= 1'b0;
            irq_en_r     <= 1'b0;
            load_r       <= '0;
            expired_r    <= 1'b0;
            proterr_r    <= 1'b0;
            irq_r        <= 1'b0;
        end else begin
            if (latch) begin
                addr_q  <= Paddr[7:2];
                write_q <= Pwrite;
                rdata_q <= Pwrite ? 32'd0 : rd_mux;
            end
            en_r <= en_next;
            if (w_ctrl) begin
                autoreload_r <= Pwdata[CTRL_AUTORELOAD];
                irq_en_r     <= Pwdata[CTRL_IRQ_EN];
            end
            if (w_load) load_r <= Pwdata[CNT_W-1:0];
            // Set beats write-1-to-clear in the same cycle.
            expired_r <= expire | (expired_r & ~(w_status & Pwdata[STAT_EXPIRED]));
            proterr_r <= proto_err | (proterr_r & ~(w_status & Pwdata[STAT_PROTERR]));
            irq_r     <= expired_r & irq_en_r;
        end
    end

    // A mismatched enable cycle returns zero instead of the captured data.
    assign Prdata    = (enable_ok && !write_q) ? rdata_q : 32'd0;
    assign Irq       = irq_r;
    assign fsm_state = state;

    apb_timer_core #(
        .PRESCALE(PRESCALE),
        .CNT_W   (CNT_W)
    ) u_core (
        .clk        (Hclk),
        .rst        (Hreset),
        .en         (en_r),
        .autoreload (autoreload_r),
        .load_val   (load_r),
        .load_strobe(en_rise),
        .count      (count),
        .expire     (expire)
    );

endmodule

// File: tb/tb_apb_timer_completer.sv
// tb_apb_timer_completer
//   Self-checking bench: reset checks, a table of register vectors, directed
//   timer / protocol / reset sequences, then randomized traffic compared with
//   a transaction-level model that advances the timer arithmetically.
module tb_apb_timer_completer;
    import apb_timer_pkg::*;

    // ---------------- clock / reset ----------------
    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic        Psel = 1'b0, Penable = 1'b0, Pwrite = 1'b0;
    logic [31:0] Paddr = '0, Pwdata = '0;
    logic [31:0] Prdata;
    logic        Irq;
    apb_state_e  fsm_state;

    apb_timer_completer #(.PRESCALE(1), .CNT_W(32)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Psel(Psel), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
        .Irq(Irq), .fsm_state(fsm_state)
    );

    always #5 Hclk = ~Hclk;

    int unsigned edge_cnt = 0;
    always @(posedge Hclk) edge_cnt <= edge_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd;
    logic        last_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic drive_cycle(input logic sel, input logic en, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
        Psel = sel; Penable = en; Pwrite = wr; Paddr = addr; Pwdata = data;
        @(negedge Hclk);
        last_rd  = Prdata;
        last_irq = Irq;
        @(posedge Hclk);
        #1;
    endtask

    task automatic idle(input int n);
        Psel = 1'b0; Penable = 1'b0;
        repeat (n) begin
            @(posedge Hclk);
            #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        drive_cycle(1'b1, 1'b0, 1'b1, addr, data);
        drive_cycle(1'b1, 1'b1, 1'b1, addr, data);
        Psel = 1'b0; Penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] rd);
        drive_cycle(1'b1, 1'b0, 1'b0, addr, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b0, addr, 32'd0);
        Psel = 1'b0; Penable = 1'b0;
        rd = last_rd;
    endtask

    task automatic do_reset();
        Hreset = 1'b1;
        idle(2);
        Hreset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic        m_en, m_ar, m_ie, m_expired, m_proterr, m_irq;
    int unsigned m_load, m_count;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_expired = 0; m_proterr = 0; m_irq = 0;
        m_load = 0; m_count = 0;
    endtask

    // Timer evolution over n clock edges with no register writes.
    task automatic advance_span(input int n);
        longint unsigned r;
        if (m_en && n > 0) begin
            if (longint'(n) <= longint'(m_count)) begin
                m_count = m_count - n;
            end else begin
                m_expired = 1'b1;
                if (m_ar) begin
                    r = longint'(n) - longint'(m_count) - 1;
                    m_count = m_load - int'(r % (longint'(m_load) + 1));
                end else begin
                    m_count = 0;
                    m_en    = 1'b0;
                end
            end
        end
    endtask

    task automatic advance(input int n);
        if (n > 1) advance_span(n - 1);
        m_irq = m_expired & m_ie;
        advance_span(1);
    endtask

    // One edge that also commits a write to word offset 'word'.
    task automatic model_commit_write(input int word, input logic [31:0] data);
        logic exp_now, en_old, ar_old, expd_old;
        exp_now  = m_en && (m_count == 0);
        en_old   = m_en;
        ar_old   = m_ar;
        expd_old = m_expired;
        m_irq    = m_expired & m_ie;
        advance_span(1);
        case (word)
            0: begin
                m_en = data[0] && !(exp_now && !ar_old);
                m_ar = data[1];
                m_ie = data[2];
                if (data[0] && !en_old) m_count = m_load;
            end
            1: m_load = data;
            3: begin
                m_expired = exp_now | (expd_old & ~data[0]);
                m_proterr = m_proterr & ~data[1];
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] model_read(input int word);
        case (word)
            0: return {29'd0, m_ie, m_ar, m_en};
            1: return m_load;
            2: return m_count;
            3: return {30'd0, m_proterr, m_expired};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_addr(input int word);
        return ($urandom() & 32'hFFFF_FF03) | (32'(word) << 2);
    endfunction

    task automatic rand_write(input int word, input logic [31:0] data);
        apb_write(rand_addr(word), data);
        advance(1);
        model_commit_write(word, data);
    endtask

    task automatic rand_read(input int word);
        logic [31:0] exp_v, rd;
        exp_v = model_read(word);
        apb_read(rand_addr(word), rd);
        advance(1);
        check($sformatf("rand_irq_w%0d", word), 32'(last_irq), 32'(m_irq));
        check($sformatf("rand_rd_w%0d", word), rd, exp_v);
        advance(1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    logic [31:0] rd;
    int unsigned e0, k;
    int          op, n, w;
    logic [31:0] data;

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0004, 32'h5A5A_0001, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h5A5A_0001};
        vecs[6]  = '{1'b1, 32'h0000_0008, 32'h0000_0123, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF6, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0000_0006};
        vecs[12] = '{1'b1, 32'h0000_000C, 32'h0000_0003, 32'h0};
        vecs[13] = '{1'b0, 32'h0000_000C, 32'h0, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0000, 32'h0, 32'h0};
        vecs[15] = '{1'b0, 32'hABCD_0104, 32'h0, 32'h5A5A_0001};

        // Reset state
        do_reset();
        check("reset_prdata", Prdata, 32'd0);
        check("reset_irq", 32'(Irq), 32'd0);
        check("reset_fsm", 32'(fsm_state), 32'(ST_IDLE));

        // Table-driven register access, all back-to-back
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, rd);
                check($sformatf("table_%0d", i), rd, vecs[i].exp);
            end
        end

        // One-shot: LOAD=5, CTRL=EN|IRQ_EN
        idle(1);
        apb_write(32'h4, 32'd5);
        apb_write(32'h0, 32'h5);
        idle(4);
        apb_read(32'hC, rd);
        check("oneshot_status_before", rd, 32'h0);
        check("oneshot_irq_before", 32'(Irq), 32'd0);
        apb_read(32'hC, rd);
        check("oneshot_status_at6", rd, 32'h1);
        check("oneshot_irq_at7", 32'(last_irq), 32'd1);
        apb_read(32'h0, rd);
        check("oneshot_ctrl", rd, 32'h4);
        apb_read(32'h8, rd);
        check("oneshot_count", rd, 32'h0);
        apb_write(32'h0, 32'h0);
        apb_write(32'hC, 32'h1);

        // Auto-reload: LOAD=3, CTRL=0x7, period 4
        apb_write(32'h4, 32'd3);
        apb_write(32'h0, 32'h7);
        e0 = edge_cnt;
        for (int j = 0; j < 6; j++) begin
            if (j == 4) idle(1);
            k = edge_cnt - e0;
            apb_read(32'h8, rd);
            check($sformatf("reload_count_%0d", j), rd, 32'(3 - (k % 4)));
        end
        while (((edge_cnt - e0 + 2) % 4) != 0) idle(1);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd);
        check("w1c_vs_set", rd, 32'h1);
        while (((edge_cnt - e0 + 2) % 4) != 1) idle(1);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd);
        check("w1c_clear", rd, 32'h0);
        apb_write(32'h0, 32'h0);
        apb_write(32'hC, 32'h1);
        apb_read(32'hC, rd);
        check("stopped_status", rd, 32'h0);

        // Protocol errors
        idle(1);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(1);
        apb_read(32'hC, rd);
        check("perr_enable_no_setup", rd, 32'h2);
        apb_write(32'hC, 32'h2);
        apb_write(32'h4, 32'h33);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h4, 32'h77);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0, 32'h77);
        check("perr_wr_prdata", last_rd, 32'h0);
        idle(1);
        apb_read(32'h4, rd);
        check("perr_load_kept", rd, 32'h33);
        apb_read(32'h0, rd);
        check("perr_ctrl_kept", rd, 32'h0);
        apb_read(32'hC, rd);
        check("perr_addr_change", rd, 32'h2);
        apb_write(32'hC, 32'h2);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
        drive_cycle(1'b1, 1'b1, 1'b0, 32'h8, 32'h0);
        check("perr_rd_prdata", last_rd, 32'h0);
        idle(1);
        apb_write(32'hC, 32'h2);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h4, 32'h55);
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h4, 32'h55);
        idle(1);
        apb_read(32'h4, rd);
        check("perr_dir_load_kept", rd, 32'h33);
        apb_read(32'hC, rd);
        check("perr_dir_change", rd, 32'h2);
        apb_write(32'hC, 32'h2);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        apb_read(32'hC, rd);
        check("perr_missing_enable", rd, 32'h2);
        apb_write(32'hC, 32'h2);

        // Back-to-back write then read, unmapped read
        apb_write(32'h4, 32'hA);
        apb_read(32'h4, rd);
        check("b2b_load", rd, 32'hA);
        apb_read(32'h10, rd);
        check("unmapped_0x10", rd, 32'h0);

        // Reset during the enable cycle of a CTRL write
        apb_write(32'h4, 32'h2);
        drive_cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h1);
        Hreset = 1'b1;
        drive_cycle(1'b1, 1'b1, 1'b1, 32'h0, 32'h1);
        Hreset = 1'b0;
        idle(5);
        apb_read(32'h0, rd);
        check("rst_mid_ctrl", rd, 32'h0);
        apb_read(32'hC, rd);
        check("rst_mid_status", rd, 32'h0);
        apb_read(32'h4, rd);
        check("rst_mid_load", rd, 32'h0);

        // Randomized traffic against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: begin
                    n = $urandom_range(1, 3);
                    idle(n);
                    advance(n);
                end
                2: rand_write(1, 32'($urandom_range(0, 9)));
                3: begin
                    data = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 2) != 0) data[0] = 1'b1;
                    rand_write(0, data);
                end
                4: rand_write(3, 32'($urandom_range(0, 3)));
                5: begin
                    w = $urandom_range(4, 7);
                    if (w == 4) w = 2;
                    rand_write(w, $urandom());
                end
                default: rand_read($urandom_range(0, 7));
            endcase
        end
        check("rand_irq_end", 32'(Irq), 32'(m_irq));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
